// File: rtl/lrwait_tail_ctrl.sv
// LRWait/SCWait queue tail controller in front of a TCDM bank: owns per-address reservation slots
// and a one-entry local response buffer. Optional build macro: LRWAIT_ERROR_ON_FULL_EN.
module lrwait_tail_ctrl #(
    parameter int unsigned NumSlots  = 4,
    parameter int unsigned MetaWidth = 16,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] in_qaddr_i,
    input  logic [31:0]          in_qdata_i,
    input  logic                 in_qwrite_i,
    input  logic                 in_qlrwait_i,
    input  logic [3:0]           in_qamo_i,
    input  logic [3:0]           in_qstrb_i,
    input  logic [MetaWidth-1:0] in_qmeta_i,
    input  logic                 in_qvalid_i,
    output logic                 in_qready_o,
    output logic [31:0]          in_pdata_o,
    output logic [MetaWidth-1:0] in_pmeta_o,
    output logic                 in_perror_o,
    output logic                 in_plrwait_o,
    output logic                 in_pvalid_o,
    input  logic                 in_pready_i,
    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic                 bank_tag_o,
    output logic [AddrWidth-1:0] bank_addr_o,
    output logic [31:0]          bank_wdata_o,
    output logic [3:0]           bank_be_o,
    output logic [3:0]           bank_amo_o,
    output logic [MetaWidth-1:0] bank_meta_o,
    input  logic                 bank_gnt_i,
    input  logic                 bank_rvalid_i,
    input  logic                 bank_rtag_i,
    input  logic [31:0]          bank_rdata_i,
    input  logic [MetaWidth-1:0] bank_rmeta_i,
    output logic                 bank_rready_o
);

    localparam int unsigned IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam logic [3:0] AmoNone   = 4'h0;
    localparam logic [3:0] AmoLrWait = 4'hC;
    localparam logic [3:0] AmoScWait = 4'hD;

    logic [NumSlots-1:0]  slot_valid_q, slot_valid_d;
    logic [AddrWidth-1:0] slot_addr_q [NumSlots];
    logic [AddrWidth-1:0] slot_addr_d [NumSlots];
    logic [MetaWidth-1:0] slot_head_q [NumSlots];
    logic [MetaWidth-1:0] slot_head_d [NumSlots];
    logic [MetaWidth-1:0] slot_tail_q [NumSlots];
    logic [MetaWidth-1:0] slot_tail_d [NumSlots];

    logic                 lrb_valid_q, lrb_valid_d;
    logic [31:0]          lrb_data_q, lrb_data_d;
    logic [MetaWidth-1:0] lrb_meta_q, lrb_meta_d;
    logic                 lrb_lrwait_q, lrb_lrwait_d;
    logic                 lrb_error_q, lrb_error_d;

    logic                 is_lrwait, is_wakeup, is_scwait;
    logic                 match_hit, free_hit;
    logic [IdxWidth-1:0]  match_idx, free_idx;
    logic                 req_ready, hs;
    logic                 lrb_push, lrb_pop;
    logic [31:0]          push_data;
    logic [MetaWidth-1:0] push_meta;
    logic                 push_lrwait, push_error;

    assign is_wakeup = (in_qamo_i == AmoLrWait) && in_qlrwait_i;
    assign is_lrwait = (in_qamo_i == AmoLrWait) && !in_qlrwait_i;
    assign is_scwait = (in_qamo_i == AmoScWait);
    assign hs        = in_qvalid_i && bank_gnt_i;

    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            if (!match_hit && slot_valid_q[i] && (slot_addr_q[i] == in_qaddr_i)) begin
                match_hit = 1'b1;
                match_idx = IdxWidth'(i);
            end
        end
    end

    // Descending scan so the lowest free index wins.
    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
            if (!slot_valid_q[i]) begin
                free_hit = 1'b1;
                free_idx = IdxWidth'(i);
            end
        end
    end

    always_comb begin
        bank_req_o   = 1'b0;
        bank_we_o    = in_qwrite_i;
        bank_tag_o   = 1'b0;
        bank_addr_o  = in_qaddr_i;
        bank_wdata_o = in_qdata_i;
        bank_be_o    = in_qstrb_i;
        bank_amo_o   = in_qamo_i;
        bank_meta_o  = in_qmeta_i;
        req_ready    = 1'b0;
        lrb_push     = 1'b0;
        push_data    = '0;
        push_meta    = in_qmeta_i;
        push_lrwait  = 1'b0;
        push_error   = 1'b0;
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_head_d  = slot_head_q;
        slot_tail_d  = slot_tail_q;

        if (is_wakeup) begin
            if (match_hit) begin
                bank_req_o  = in_qvalid_i;
                bank_we_o   = 1'b0;
                bank_amo_o  = AmoNone;
                bank_meta_o = in_qdata_i[MetaWidth-1:0];
                req_ready   = bank_gnt_i;
                if (hs) slot_head_d[match_idx] = in_qdata_i[MetaWidth-1:0];
            end else begin
                req_ready = 1'b1;
            end
        end else if (is_lrwait) begin
            if (match_hit) begin
                // Successor joins the queue: tell the previous tail who follows it.
                req_ready   = !lrb_valid_q;
                lrb_push    = in_qvalid_i && !lrb_valid_q;
                push_data   = 32'(in_qmeta_i);
                push_meta   = slot_tail_q[match_idx];
                push_lrwait = 1'b1;
                if (lrb_push) slot_tail_d[match_idx] = in_qmeta_i;
            end else if (free_hit) begin
                bank_req_o = in_qvalid_i;
                bank_we_o  = 1'b0;
                bank_amo_o = AmoNone;
                req_ready  = bank_gnt_i;
                if (hs) begin
                    slot_valid_d[free_idx] = 1'b1;
                    slot_addr_d[free_idx]  = in_qaddr_i;
                    slot_head_d[free_idx]  = in_qmeta_i;
                    slot_tail_d[free_idx]  = in_qmeta_i;
                end
            end else begin
`ifdef LRWAIT_ERROR_ON_FULL_EN
                req_ready  = !lrb_valid_q;
                lrb_push   = in_qvalid_i && !lrb_valid_q;
                push_error = 1'b1;
`else
                req_ready  = 1'b0;
`endif
            end
        end else if (is_scwait) begin
            if (match_hit && (slot_head_q[match_idx] == in_qmeta_i)) begin
                bank_req_o = in_qvalid_i;
                bank_we_o  = 1'b1;
                bank_tag_o = 1'b1;
                bank_amo_o = AmoNone;
                req_ready  = bank_gnt_i;
                if (hs && (slot_head_q[match_idx] == slot_tail_q[match_idx])) begin
                    slot_valid_d[match_idx] = 1'b0;
                end
            end else begin
                req_ready = !lrb_valid_q;
                lrb_push  = in_qvalid_i && !lrb_valid_q;
                push_data = 32'd1;
            end
        end else begin
            bank_req_o = in_qvalid_i;
            req_ready  = bank_gnt_i;
        end
    end

    assign in_qready_o = rst_ni && req_ready;

    // Bank responses always win; the buffered entry waits for an idle response channel.
    assign lrb_pop       = lrb_valid_q && !bank_rvalid_i && in_pready_i;
    assign bank_rready_o = in_pready_i;
    assign in_pvalid_o   = bank_rvalid_i || lrb_valid_q;

    always_comb begin
        in_pdata_o   = '0;
        in_pmeta_o   = '0;
        in_perror_o  = 1'b0;
        in_plrwait_o = 1'b0;
        if (bank_rvalid_i) begin
            in_pdata_o = bank_rtag_i ? 32'd0 : bank_rdata_i;
            in_pmeta_o = bank_rmeta_i;
        end else if (lrb_valid_q) begin
            in_pdata_o   = lrb_data_q;
            in_pmeta_o   = lrb_meta_q;
            in_perror_o  = lrb_error_q;
            in_plrwait_o = lrb_lrwait_q;
        end
    end

    always_comb begin
        lrb_valid_d  = lrb_valid_q;
        lrb_data_d   = lrb_data_q;
        lrb_meta_d   = lrb_meta_q;
        lrb_lrwait_d = lrb_lrwait_q;
        lrb_error_d  = lrb_error_q;
        if (lrb_push) begin
            lrb_valid_d  = 1'b1;
            lrb_data_d   = push_data;
            lrb_meta_d   = push_meta;
            lrb_lrwait_d = push_lrwait;
            lrb_error_d  = push_error;
        end else if (lrb_pop) begin
            lrb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            for (int i = 0; i < int'(NumSlots); i++) begin
                slot_addr_q[i] <= '0;
                slot_head_q[i] <= '0;
                slot_tail_q[i] <= '0;
            end
            lrb_valid_q  <= 1'b0;
            lrb_data_q   <= '0;
            lrb_meta_q   <= '0;
            lrb_lrwait_q <= 1'b0;
            lrb_error_q  <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_head_q  <= slot_head_d;
            slot_tail_q  <= slot_tail_d;
            lrb_valid_q  <= lrb_valid_d;
            lrb_data_q   <= lrb_data_d;
            lrb_meta_q   <= lrb_meta_d;
            lrb_lrwait_q <= lrb_lrwait_d;
            lrb_error_q  <= lrb_error_d;
        end
    end

endmodule

// File: tb/tb_lrwait_tail_ctrl.sv
// Randomized self-checking bench for lrwait_tail_ctrl against a queue-of-reservations model.
module tb_lrwait_tail_ctrl;

    localparam int NUM_SLOTS = 4;
    localparam logic [3:0] LR = 4'hC;
    localparam logic [3:0] SC = 4'hD;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] in_qaddr_i = '0, in_qdata_i = '0;
    logic        in_qwrite_i = 1'b0, in_qlrwait_i = 1'b0;
    logic [3:0]  in_qamo_i = '0, in_qstrb_i = 4'hF;
    logic [15:0] in_qmeta_i = '0;
    logic        in_qvalid_i = 1'b0;
    logic        in_qready_o;
    logic [31:0] in_pdata_o;
    logic [15:0] in_pmeta_o;
    logic        in_perror_o, in_plrwait_o, in_pvalid_o;
    logic        in_pready_i = 1'b1;
    logic        bank_req_o, bank_we_o, bank_tag_o;
    logic [31:0] bank_addr_o, bank_wdata_o;
    logic [3:0]  bank_be_o, bank_amo_o;
    logic [15:0] bank_meta_o;
    logic        bank_gnt_i = 1'b1;
    logic        bank_rvalid_i = 1'b0, bank_rtag_i = 1'b0;
    logic [31:0] bank_rdata_i = '0;
    logic [15:0] bank_rmeta_i = '0;
    logic        bank_rready_o;

    lrwait_tail_ctrl #(.NumSlots(NUM_SLOTS), .MetaWidth(16), .AddrWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_qaddr_i(in_qaddr_i), .in_qdata_i(in_qdata_i), .in_qwrite_i(in_qwrite_i),
        .in_qlrwait_i(in_qlrwait_i), .in_qamo_i(in_qamo_i), .in_qstrb_i(in_qstrb_i),
        .in_qmeta_i(in_qmeta_i), .in_qvalid_i(in_qvalid_i), .in_qready_o(in_qready_o),
        .in_pdata_o(in_pdata_o), .in_pmeta_o(in_pmeta_o), .in_perror_o(in_perror_o),
        .in_plrwait_o(in_plrwait_o), .in_pvalid_o(in_pvalid_o), .in_pready_i(in_pready_i),
        .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_tag_o(bank_tag_o),
        .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o),
        .bank_amo_o(bank_amo_o), .bank_meta_o(bank_meta_o), .bank_gnt_i(bank_gnt_i),
        .bank_rvalid_i(bank_rvalid_i), .bank_rtag_i(bank_rtag_i), .bank_rdata_i(bank_rdata_i),
        .bank_rmeta_i(bank_rmeta_i), .bank_rready_o(bank_rready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass = 0;
    bit rand_gnt = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    // Reservations in arrival order: address plus queue head and tail requester.
    typedef struct {
        logic [31:0] addr;
        logic [15:0] head;
        logic [15:0] tail;
    } resv_t;
    resv_t resv[$];

    function automatic int find_resv(input logic [31:0] a);
        for (int i = 0; i < resv.size(); i++) if (resv[i].addr == a) return i;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input logic lw, input logic [3:0] amo, input logic [15:0] m);
        int          i;
        resv_t       r;
        bit          g, exp_req, exp_we, exp_tag, exp_rdy, bank_op, push, perr, plw;
        logic [15:0] exp_bmeta, push_meta;
        logic [31:0] push_data, rd;
        logic [3:0]  exp_amo;
        g = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
        i = find_resv(a);
        exp_req = 0; exp_we = w; exp_tag = 0; exp_rdy = 0; push = 0; perr = 0; plw = 0;
        exp_bmeta = m; push_meta = m; push_data = '0; exp_amo = 4'h0;
        if (amo == LR && lw) begin
            if (i >= 0) begin
                exp_req = 1; exp_we = 0; exp_bmeta = d[15:0]; exp_rdy = g;
            end else exp_rdy = 1;
        end else if (amo == LR) begin
            if (i >= 0) begin
                exp_rdy = 1; push = 1; plw = 1; push_meta = resv[i].tail; push_data = {16'h0, m};
            end else if (resv.size() < NUM_SLOTS) begin
                exp_req = 1; exp_we = 0; exp_rdy = g;
            end else begin
`ifdef LRWAIT_ERROR_ON_FULL_EN
                exp_rdy = 1; push = 1; perr = 1;
`endif
            end
        end else if (amo == SC) begin
            if (i >= 0 && resv[i].head == m) begin
                exp_req = 1; exp_we = 1; exp_tag = 1; exp_rdy = g;
            end else begin
                exp_rdy = 1; push = 1; push_data = 32'd1;
            end
        end else begin
            exp_req = 1; exp_rdy = g; exp_amo = amo;
        end
        bank_op = exp_req && exp_rdy;

        in_qaddr_i = a; in_qdata_i = d; in_qwrite_i = w; in_qlrwait_i = lw;
        in_qamo_i = amo; in_qmeta_i = m; in_qvalid_i = 1'b1; bank_gnt_i = g;
        @(negedge clk_i);
        check("qready", 32'(in_qready_o), 32'(exp_rdy));
        check("bank_req", 32'(bank_req_o), 32'(exp_req));
        if (exp_req) begin
            check("bank_we", 32'(bank_we_o), 32'(exp_we));
            check("bank_tag", 32'(bank_tag_o), 32'(exp_tag));
            check("bank_amo", 32'(bank_amo_o), 32'(exp_amo));
            check("bank_meta", 32'(bank_meta_o), 32'(exp_bmeta));
            check("bank_addr", bank_addr_o, a);
            if (exp_we) check("bank_wdata", bank_wdata_o, d);
        end
        next_cycle();
        in_qvalid_i = 1'b0;
        bank_gnt_i = 1'b1;
        if (exp_rdy) begin
            if (amo == LR && lw && i >= 0) begin
                r = resv[i]; r.head = d[15:0]; resv[i] = r;
            end else if (amo == LR && !lw && i >= 0) begin
                r = resv[i]; r.tail = m; resv[i] = r;
            end else if (amo == LR && !lw && exp_req) begin
                r.addr = a; r.head = m; r.tail = m; resv.push_back(r);
            end else if (amo == SC && exp_req && resv[i].head == resv[i].tail) begin
                resv.delete(i);
            end
        end
        @(negedge clk_i);
        check("lrb_pvalid", 32'(in_pvalid_o), 32'(push));
        if (push) begin
            check("lrb_data", in_pdata_o, push_data);
            check("lrb_meta", 32'(in_pmeta_o), 32'(push_meta));
            check("lrb_lrwait", 32'(in_plrwait_o), 32'(plw));
            check("lrb_error", 32'(in_perror_o), 32'(perr));
        end
        next_cycle();
        if (bank_op) begin
            rd = $urandom | 32'h1;
            bank_rvalid_i = 1'b1; bank_rtag_i = exp_tag; bank_rdata_i = rd;
            bank_rmeta_i = exp_bmeta;
            @(negedge clk_i);
            check("bank_pvalid", 32'(in_pvalid_o), 32'd1);
            check("bank_pdata", in_pdata_o, exp_tag ? 32'd0 : rd);
            check("bank_pmeta", 32'(in_pmeta_o), 32'(exp_bmeta));
            check("bank_plrwait", 32'(in_plrwait_o), 32'd0);
            check("bank_rready", 32'(bank_rready_o), 32'(in_pready_i));
            next_cycle();
            bank_rvalid_i = 1'b0; bank_rtag_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        in_qvalid_i = 1'b1; in_qamo_i = 4'h0; in_qlrwait_i = 1'b0; bank_gnt_i = 1'b1;
        @(negedge clk_i);
        check("rst_qready", 32'(in_qready_o), 32'd0);
        check("rst_pvalid", 32'(in_pvalid_o), 32'd0);
        in_qvalid_i = 1'b0;
        resv.delete();
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    initial begin
        int kind;
        logic [31:0] a;
        logic [15:0] m;
        int i;
        next_cycle();
        do_reset();

        // Uncontended reservation, contention, handover and release.
        run_op(32'h100, 32'h0, 1'b0, 1'b0, LR, 16'h11);
        run_op(32'h100, 32'h0, 1'b0, 1'b0, LR, 16'h22);
        run_op(32'h100, 32'hDEAD, 1'b1, 1'b0, SC, 16'h11);
        run_op(32'h100, 32'h22, 1'b0, 1'b1, LR, 16'h11);
        run_op(32'h100, 32'hBEEF, 1'b1, 1'b0, SC, 16'h22);
        run_op(32'h200, 32'h5, 1'b1, 1'b0, SC, 16'h33);
        run_op(32'h300, 32'h22, 1'b0, 1'b1, LR, 16'h44);

        // Fill all slots, hit the full case, free one and retry.
        for (int k = 0; k < NUM_SLOTS; k++) run_op(32'h400 + 32'(4 * k), 0, 0, 0, LR, 16'(k + 1));
        run_op(32'h500, 32'h0, 1'b0, 1'b0, LR, 16'h55);
        run_op(32'h400, 32'h7, 1'b1, 1'b0, SC, 16'h1);
        run_op(32'h500, 32'h0, 1'b0, 1'b0, LR, 16'h55);

        // SuccUpdate colliding with bank responses, and a second contender stalled on the buffer.
        do_reset();
        run_op(32'h100, 32'h0, 1'b0, 1'b0, LR, 16'h11);
        bank_rvalid_i = 1'b1; bank_rtag_i = 1'b0; bank_rdata_i = 32'hAAAA; bank_rmeta_i = 16'h11;
        in_qaddr_i = 32'h100; in_qamo_i = LR; in_qlrwait_i = 1'b0; in_qmeta_i = 16'h22;
        in_qvalid_i = 1'b1;
        @(negedge clk_i);
        check("col_qready0", 32'(in_qready_o), 32'd1);
        check("col_bankreq0", 32'(bank_req_o), 32'd0);
        check("col_pmeta0", 32'(in_pmeta_o), 32'h11);
        check("col_pdata0", in_pdata_o, 32'hAAAA);
        next_cycle();
        bank_rdata_i = 32'hBBBB; bank_rmeta_i = 16'h55; in_qmeta_i = 16'h33;
        @(negedge clk_i);
        check("col_qready1", 32'(in_qready_o), 32'd0);
        check("col_pmeta1", 32'(in_pmeta_o), 32'h55);
        check("col_plrwait1", 32'(in_plrwait_o), 32'd0);
        next_cycle();
        bank_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("col_succ_valid", 32'(in_pvalid_o), 32'd1);
        check("col_succ_meta", 32'(in_pmeta_o), 32'h11);
        check("col_succ_data", in_pdata_o, 32'h22);
        check("col_succ_lrwait", 32'(in_plrwait_o), 32'd1);
        check("col_qready2", 32'(in_qready_o), 32'd0);
        next_cycle();
        @(negedge clk_i);
        check("col_qready3", 32'(in_qready_o), 32'd1);
        next_cycle();
        in_qvalid_i = 1'b0;
        @(negedge clk_i);
        check("col_succ2_meta", 32'(in_pmeta_o), 32'h22);
        check("col_succ2_data", in_pdata_o, 32'h33);
        check("col_succ2_lrwait", 32'(in_plrwait_o), 32'd1);
        next_cycle();
        resv.delete();
        begin
            resv_t r;
            r.addr = 32'h100; r.head = 16'h11; r.tail = 16'h33;
            resv.push_back(r);
        end
        run_op(32'h100, 32'h0, 1'b0, 1'b0, LR, 16'h44);

        // Reset with reservations held, then a fresh LRWait must go to the bank.
        run_op(32'h104, 32'h0, 1'b0, 1'b0, LR, 16'h12);
        do_reset();
        run_op(32'h100, 32'h0, 1'b0, 1'b0, LR, 16'h66);

        // Randomized traffic over a small address pool so queues and full slots recur.
        rand_gnt = 1'b1;
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 99);
            a = 32'h100 + 32'(4 * $urandom_range(0, 5));
            m = 16'($urandom_range(1, 8));
            i = find_resv(a);
            if (kind < 35) begin
                run_op(a, $urandom, 1'b0, 1'b0, LR, m);
            end else if (kind < 65) begin
                if (i >= 0 && $urandom_range(0, 9) < 6) m = resv[i].head;
                run_op(a, $urandom, 1'b1, 1'b0, SC, m);
            end else if (kind < 80) begin
                if (i >= 0 && $urandom_range(0, 1) == 1) run_op(a, 32'(resv[i].tail), 0, 1, LR, m);
                else run_op(a, 32'($urandom_range(1, 8)), 1'b0, 1'b1, LR, m);
            end else begin
                run_op(a, $urandom, 1'($urandom_range(0, 1)), 1'b0,
                       ($urandom_range(0, 1) == 1) ? 4'h2 : 4'h0, m);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
